// File: rtl/and_gate_vector_sequencer_pkg.sv
// Shared definitions for the AND-gate vector sequencer: FSM state encoding,
// vector count and the {a,b} stimulus table.
package and_gate_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } seq_state_e;

    localparam int NUM_VEC = 9;
    localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

    // Packed as {idx8 .. idx0}; each entry is {a,b}.
    localparam logic [NUM_VEC-1:0][1:0] VEC_TABLE = {
        2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00
    };

    function automatic logic [1:0] vec_ab(input logic [3:0] idx);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (idx == 4'(i)) r = VEC_TABLE[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/and_gate_vector_sequencer_hold_counter.sv
// Dwell counter: counts from its start value toward MAX (up) or 0 (down)
// while enabled, stops there and flags terminal count.
module hold_counter #(
    parameter int MAX = 9,
    parameter bit UP  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [W-1:0] CNT_START = UP ? '0 : W'(MAX);
    localparam logic [W-1:0] CNT_END   = UP ? W'(MAX) : '0;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_START;
        end else if (clr) begin
            cnt <= CNT_START;
        end else if (en && !tc) begin
            cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

    assign tc = (cnt == CNT_END);

endmodule

// File: rtl/and_gate_vector_sequencer.sv
// Drives a 2-input AND gate through a fixed 9-vector table, samples the gate
// output after each dwell and reports a saturating error count plus pass flag.
module and_gate_vector_sequencer
    import and_gate_vector_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int NUM_PASSES  = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       vec_idx
);
    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [PC_W-1:0] LAST_PASS = PC_W'(NUM_PASSES - 1);

    seq_state_e      state;
    logic [PC_W-1:0] pass_cnt;
    logic            hold_tc;

    // Counter is held clear outside DRIVE so each vector starts its dwell at 0.
    hold_counter #(
        .MAX (HOLD_CYCLES - 1),
        .UP  (1'b1)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != S_DRIVE),
        .en    (state == S_DRIVE),
        .tc    (hold_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_idx   <= '0;
            pass_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        {a, b}    <= vec_ab(4'd0);
                        busy      <= 1'b1;
                        vec_idx   <= '0;
                        pass_cnt  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (hold_tc) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if ((dut_out != (a & b)) && (err_count != '1))
                        err_count <= err_count + 1'b1;
                    // a/b are updated on the same edge that leaves SAMPLE, so the
                    // next vector is already driven on the first DRIVE cycle.
                    if (vec_idx == LAST_IDX) begin
                        if (pass_cnt == LAST_PASS) begin
                            state <= S_DONE;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_DRIVE;
                            vec_idx  <= '0;
                            pass_cnt <= pass_cnt + 1'b1;
                            {a, b}   <= vec_ab(4'd0);
                        end
                    end else begin
                        state   <= S_DRIVE;
                        vec_idx <= vec_idx + 4'd1;
                        {a, b}  <= vec_ab(vec_idx + 4'd1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    a     <= 1'b0;
                    b     <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_gate_vector_sequencer.sv
// Directed bench for and_gate_vector_sequencer: three instances cover the default
// configuration, a two-pass OR-gate run and a 2-bit saturating error counter.
module tb_and_gate_vector_sequencer;

    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] tbl [9] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};

    // dut1: defaults, gate model selectable (0 = AND, 1 = stuck-at-1)
    logic       start1 = 1'b0, gate_mode = 1'b0;
    logic       a1, b1, out1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] idx1;
    assign out1 = gate_mode ? 1'b1 : (a1 & b1);

    // dut2: NUM_PASSES=2, OR gate in place of AND
    logic       start2 = 1'b0;
    logic       a2, b2, out2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [3:0] idx2;
    assign out2 = a2 | b2;

    // dut3: ERR_W=2, stuck-at-1 gate
    logic       start3 = 1'b0;
    logic       a3, b3, out3, busy3, done3, pass3;
    logic [1:0] err3;
    logic [3:0] idx3;
    assign out3 = 1'b1;

    and_gate_vector_sequencer u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_idx(idx1));

    and_gate_vector_sequencer #(.NUM_PASSES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .dut_out(out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_idx(idx2));

    and_gate_vector_sequencer #(.ERR_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .dut_out(out3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .vec_idx(idx3));

    // Launches one run on the selected instance and counts cycles from the
    // accepting edge until done. For dut1 the {a,b}/idx trace is checked against
    // the table each cycle; repulse_k re-raises start at that cycle count.
    task automatic run_dut(input int sel, input int repulse_k, output int lat, output int seq_err);
        logic d;
        @(negedge clk);
        case (sel) 1: start1 = 1'b1; 2: start2 = 1'b1; default: start3 = 1'b1; endcase
        @(posedge clk);
        #1;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        lat = 0;
        seq_err = 0;
        while (lat < LIMIT) begin
            d = (sel == 1) ? done1 : (sel == 2) ? done2 : done3;
            if (d === 1'b1) break;
            if (sel == 1 && lat < 99) begin
                if ({a1, b1} !== tbl[lat / 11] || idx1 !== 4'(lat / 11)) seq_err++;
            end
            if (sel == 1) start1 = (lat == repulse_k);
            @(posedge clk);
            #1;
            lat++;
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a1, b1, busy1, done1, pass1} !== 5'b0 || err1 !== 8'd0 || idx1 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got a%b b%b busy%b done%b pass%b err%0d idx%0d, want all 0",
                     a1, b1, busy1, done1, pass1, err1, idx1);
        end
        n_checks++;
        if ({a2, b2, busy2, done2, pass2, a3, b3, busy3, done3, pass3} !== 10'b0 ||
            err2 !== 8'd0 || err3 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_dut23: outputs not zero (err2=%0d err3=%0d)", err2, err3);
        end
        start1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ideal;
        int lat, se;
        gate_mode = 1'b0;
        run_dut(1, -1, lat, se);
        n_checks++;
        if (lat !== 100) begin n_fail++; $display("FAIL ideal_latency: got %0d want 100", lat); end
        n_checks++;
        if (se !== 0) begin n_fail++; $display("FAIL ideal_ab_sequence: %0d bad cycles, want 0", se); end
        n_checks++;
        if (err1 !== 8'd0 || pass1 !== 1'b1) begin
            n_fail++; $display("FAIL ideal_result: err=%0d pass=%b, want err=0 pass=1", err1, pass1);
        end
        n_checks++;
        if (busy1 !== 1'b0 || a1 !== 1'b0 || b1 !== 1'b0) begin
            n_fail++; $display("FAIL ideal_idle_outputs: busy=%b a=%b b=%b, want 0", busy1, a1, b1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: done=%b, want 0", done1); end
    endtask

    task automatic test_stuck1;
        int lat, se;
        gate_mode = 1'b1;
        run_dut(1, -1, lat, se);
        n_checks++;
        if (lat !== 100) begin n_fail++; $display("FAIL stuck1_latency: got %0d want 100", lat); end
        n_checks++;
        if (err1 !== 8'd8) begin n_fail++; $display("FAIL stuck1_err: got %0d want 8", err1); end
        n_checks++;
        if (pass1 !== 1'b0) begin n_fail++; $display("FAIL stuck1_pass: got %b want 0", pass1); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err1 !== 8'd8 || pass1 !== 1'b0) begin
            n_fail++; $display("FAIL stuck1_hold: err=%0d pass=%b, want 8/0", err1, pass1);
        end
        gate_mode = 1'b0;
    endtask

    task automatic test_or_two_pass;
        int lat, se;
        run_dut(2, -1, lat, se);
        n_checks++;
        if (lat !== 199) begin n_fail++; $display("FAIL or2_latency: got %0d want 199", lat); end
        n_checks++;
        if (err2 !== 8'd10) begin n_fail++; $display("FAIL or2_err: got %0d want 10", err2); end
        n_checks++;
        if (pass2 !== 1'b0) begin n_fail++; $display("FAIL or2_pass: got %b want 0", pass2); end
    endtask

    task automatic test_saturate;
        int lat, se;
        run_dut(3, -1, lat, se);
        n_checks++;
        if (lat !== 100) begin n_fail++; $display("FAIL sat_latency: got %0d want 100", lat); end
        n_checks++;
        if (err3 !== 2'd3) begin n_fail++; $display("FAIL sat_err: got %0d want 3", err3); end
        n_checks++;
        if (pass3 !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b want 0", pass3); end
    endtask

    task automatic test_restart_ignored;
        int lat, se;
        gate_mode = 1'b0;
        run_dut(1, 3 * 11 + 2, lat, se);
        n_checks++;
        if (lat !== 100) begin n_fail++; $display("FAIL repulse_latency: got %0d want 100", lat); end
        n_checks++;
        if (se !== 0) begin n_fail++; $display("FAIL repulse_ab_sequence: %0d bad cycles, want 0", se); end
        n_checks++;
        if (err1 !== 8'd0 || pass1 !== 1'b1) begin
            n_fail++; $display("FAIL repulse_result: err=%0d pass=%b, want 0/1", err1, pass1);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, se;
        gate_mode = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4 * 11 + 3) @(posedge clk);
        #1;
        n_checks++;
        if (idx1 !== 4'd4 || busy1 !== 1'b1 || err1 !== 8'd3) begin
            n_fail++; $display("FAIL midrun_state: idx=%0d busy=%b err=%0d, want 4/1/3", idx1, busy1, err1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a1 !== 1'b0 || b1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 8'd0 || idx1 !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: a=%b b=%b busy=%b err=%0d idx=%0d, want 0",
                               a1, b1, busy1, err1, idx1);
        end
        gate_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_dut(1, -1, lat, se);
        n_checks++;
        if (lat !== 100 || se !== 0) begin
            n_fail++; $display("FAIL post_reset_run: latency=%0d bad_cycles=%0d, want 100/0", lat, se);
        end
        n_checks++;
        if (err1 !== 8'd0 || pass1 !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_result: err=%0d pass=%b, want 0/1", err1, pass1);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck1();
        test_or_two_pass();
        test_saturate();
        test_restart_ignored();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
